// File: rtl/imm_gen_pipe.sv
// RV32I immediate generator: opcode decode plus sign-extended immediate, 1-cycle latency, 2-entry skid buffer.
// Optional macro IMM_GEN_ILLEGAL_CNT_EN adds a saturating 16-bit count of accepted illegal instructions.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
`ifdef IMM_GEN_ILLEGAL_CNT_EN
  ,
  output logic [15:0]      illegal_cnt
`endif
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } ent_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t      state_q, state_d;
  ent_t        out_q, out_d;
  ent_t        skid_q, skid_d;
  ent_t        dec;
  logic [31:0] imm32;
  logic        in_ready_q;
  logic        push;
  logic        pop;

  // Decode happens before the register so the output slot holds a finished result.
  always_comb begin
    imm32   = '0;
    dec     = '0;
    dec.tag = in_tag;
    case (in_instr[6:0])
      OP_LUI, OP_AUIPC: begin
        dec.fmt = FMT_U;
        imm32   = {in_instr[31:12], 12'b0};
      end
      OP_JAL: begin
        dec.fmt = FMT_J;
        imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
      end
      OP_JALR, OP_LOAD, OP_OPIMM, OP_SYSTEM, OP_FENCE: begin
        dec.fmt = FMT_I;
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OP_STORE: begin
        dec.fmt = FMT_S;
        imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OP_BRANCH: begin
        dec.fmt = FMT_B;
        imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
      end
      OP_OP: dec.fmt = FMT_R;
      default: begin
        dec.fmt = FMT_ILL;
        dec.ill = 1'b1;
      end
    endcase
    dec.imm = XLEN'($signed(imm32));
  end

  assign push = in_valid & in_ready_q;
  assign pop  = (state_q != EMPTY) & out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          out_d   = dec;
        end
      end
      ONE: begin
        if (push && !pop) begin
          state_d = TWO;
          skid_d  = dec;
        end else if (push && pop) begin
          out_d = dec;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_d = ONE;
          out_d   = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // in_ready is registered from the next occupancy, so out_ready never reaches it combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      out_q      <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != TWO);
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q != EMPTY);
  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_illegal = out_q.ill;
  assign out_tag     = out_q.tag;

`ifdef IMM_GEN_ILLEGAL_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (push && dec.ill && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign illegal_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomised and directed bench for imm_gen_pipe (XLEN=64) against an arithmetic FIFO model.
module tb_imm_gen_pipe;
  localparam int XLEN  = 64;
  localparam int TAG_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;
`ifdef IMM_GEN_ILLEGAL_CNT_EN
  logic [15:0]      illegal_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_imm    (out_imm),
    .out_fmt    (out_fmt),
    .out_illegal(out_illegal),
    .out_tag    (out_tag)
`ifdef IMM_GEN_ILLEGAL_CNT_EN
    ,
    .illegal_cnt(illegal_cnt)
`endif
  );

  typedef struct {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
    int               acyc;
    int               dcyc;
  } ent_t;

  ent_t q[$];
  ent_t out_log[$];
  int   exp_cnt = 0;
  logic acc = 1'b0;
  logic mon_en = 1'b0;
  logic prev_hold = 1'b0;
  logic [XLEN-1:0]  prev_imm;
  logic [TAG_W-1:0] prev_tag;
  logic [6:0] ops [0:10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h73, 7'h0F,
                             7'h23, 7'h63, 7'h33};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Immediate as a signed integer: sign weight times its bit position plus the unsigned fields.
  function automatic ent_t model(input logic [31:0] ins, input logic [TAG_W-1:0] tag);
    ent_t   e;
    longint v;
    longint s;
    s = ins[31] ? -64'sd1 : 64'sd0;
    v = 0;
    e.fmt = 3'd0; e.ill = 1'b0; e.tag = tag; e.acyc = cyc; e.dcyc = 0;
    case (ins[6:0])
      7'h37, 7'h17: begin
        e.fmt = 3'd4;
        v = s * 64'sd2147483648 + longint'(ins[30:12]) * 4096;
      end
      7'h6F: begin
        e.fmt = 3'd5;
        v = s * 64'sd1048576 + longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
            + longint'(ins[30:21]) * 2;
      end
      7'h67, 7'h03, 7'h13, 7'h73, 7'h0F: begin
        e.fmt = 3'd1;
        v = s * 2048 + longint'(ins[30:20]);
      end
      7'h23: begin
        e.fmt = 3'd2;
        v = s * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:7]);
      end
      7'h63: begin
        e.fmt = 3'd3;
        v = s * 4096 + longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
            + longint'(ins[11:8]) * 2;
      end
      7'h33: e.fmt = 3'd0;
      default: begin
        e.fmt = 3'd7;
        e.ill = 1'b1;
      end
    endcase
    e.imm = v[XLEN-1:0];
    return e;
  endfunction

  // Compare process: every cycle the DUT must look like the head of a depth-2 FIFO.
  always @(negedge clk) begin
    ent_t h;
    acc = 1'b0;
    if (mon_en) begin
      if (rst) begin
        q.delete();
        exp_cnt   = 0;
        prev_hold = 1'b0;
      end else begin
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        if (q.size() > 0) begin
          chk("out_imm", out_imm, q[0].imm);
          chk("out_fmt", 64'(out_fmt), 64'(q[0].fmt));
          chk("out_illegal", 64'(out_illegal), 64'(q[0].ill));
          chk("out_tag", 64'(out_tag), 64'(q[0].tag));
        end
        if (prev_hold) begin
          chk("stall_imm_stable", out_imm, prev_imm);
          chk("stall_tag_stable", 64'(out_tag), 64'(prev_tag));
        end
`ifdef IMM_GEN_ILLEGAL_CNT_EN
        chk("illegal_cnt", 64'(illegal_cnt), 64'(exp_cnt));
`endif
        prev_hold = out_valid && !out_ready;
        prev_imm  = out_imm;
        prev_tag  = out_tag;
        if (out_valid && out_ready && q.size() > 0) begin
          h = q.pop_front();
          h.dcyc = cyc;
          out_log.push_back(h);
        end
        if (in_valid && in_ready) begin
          h = model(in_instr, in_tag);
          q.push_back(h);
          if (h.ill && exp_cnt < 65535) exp_cnt++;
          acc = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [TAG_W-1:0] tag);
    in_valid = 1'b1;
    in_instr = ins;
    in_tag   = tag;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    n_bad++;
    $display("FAIL send_timeout: instr %0h never accepted", ins);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic chk_log(input string nm, input int idx, input logic [XLEN-1:0] imm,
                         input logic [2:0] fmt, input logic ill);
    if (out_log.size() > idx) begin
      chk({nm, "_imm"}, out_log[idx].imm, imm);
      chk({nm, "_fmt"}, 64'(out_log[idx].fmt), 64'(fmt));
      chk({nm, "_ill"}, 64'(out_log[idx].ill), 64'(ill));
    end else begin
      chk({nm, "_present"}, 64'(out_log.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ent_t m;
    logic [31:0] r;

    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b1;
    tick();
    mon_en = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_imm", out_imm, 64'd0);
    chk("reset_fmt_tag", {29'd0, out_fmt, out_tag}, 64'd0);

    // Pin the model against hand-worked values.
    m = model(32'hFFDFF06F, '0);
    chk("model_jal", m.imm, 64'hFFFF_FFFF_FFFF_FFFC);
    m = model(32'h00000463, '0);
    chk("model_beq", m.imm, 64'h8);
    m = model(32'h0020A623, '0);
    chk("model_sw", m.imm, 64'hC);

    out_log.delete();
    send(32'hFFF00093, 32'h100);
    drain();
    chk_log("addi", 0, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
    if (out_log.size() > 0) begin
      chk("addi_tag", 64'(out_log[0].tag), 64'h100);
      chk("addi_latency", 64'(out_log[0].dcyc - out_log[0].acyc), 64'd1);
    end

    out_log.delete();
    send(32'h123450B7, 32'h1);
    send(32'hFFDFF06F, 32'h2);
    drain();
    chk_log("lui", 0, 64'h1234_5000, 3'd4, 1'b0);
    chk_log("jal", 1, 64'hFFFF_FFFF_FFFF_FFFC, 3'd5, 1'b0);
    if (out_log.size() > 1)
      chk("lui_jal_consecutive", 64'(out_log[1].dcyc - out_log[0].dcyc), 64'd1);

    out_log.delete();
    send(32'h00000463, 32'h3);
    send(32'h0020A623, 32'h4);
    send(32'h002081B3, 32'h5);
    drain();
    chk_log("beq", 0, 64'h8, 3'd3, 1'b0);
    chk_log("sw", 1, 64'hC, 3'd2, 1'b0);
    chk_log("add", 2, 64'h0, 3'd0, 1'b0);

    out_log.delete();
    out_ready = 1'b0;
    send(32'h00100093, 32'hA);
    send(32'h00200093, 32'hB);
    @(negedge clk);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    chk("bp_head_tag", 64'(out_tag), 64'hA);
    @(posedge clk);
    #1;
    in_valid = 1'b1; in_instr = 32'h00300093; in_tag = 32'hC;
    repeat (3) tick();
    chk("bp_still_blocked", 64'(in_ready), 64'd0);
    chk("bp_head_held", 64'(out_tag), 64'hA);
    out_ready = 1'b1;
    send(32'h00300093, 32'hC);
    drain();
    chk("bp_count", 64'(out_log.size()), 64'd3);
    if (out_log.size() == 3)
      chk("bp_order", {out_log[0].tag[7:0], out_log[1].tag[7:0], out_log[2].tag[7:0]},
          64'h0A0B0C);

`ifdef IMM_GEN_ILLEGAL_CNT_EN
    chk("cnt_before_illegal", 64'(illegal_cnt), 64'd0);
`endif
    out_log.delete();
    send(32'h0000007F, 32'hD);
    drain();
    chk_log("illegal", 0, 64'h0, 3'd7, 1'b1);
`ifdef IMM_GEN_ILLEGAL_CNT_EN
    chk("cnt_after_illegal", 64'(illegal_cnt), 64'd1);
`endif

    out_ready = 1'b0;
    send(32'hFFF00093, 32'hE);
    send(32'h0000007F, 32'hF);
    @(negedge clk);
    chk("rst_pre_two", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_imm", out_imm, 64'd0);
    chk("midrst_fmt_ill_tag", {28'd0, out_fmt, out_illegal, out_tag}, 64'd0);
`ifdef IMM_GEN_ILLEGAL_CNT_EN
    chk("midrst_cnt", 64'(illegal_cnt), 64'd0);
`endif
    out_log.delete();
    out_ready = 1'b1;
    send(32'h00000463, 32'h77);
    drain();
    chk("post_rst_count", 64'(out_log.size()), 64'd1);
    if (out_log.size() == 1) begin
      chk("post_rst_tag", 64'(out_log[0].tag), 64'h77);
      chk("post_rst_latency", 64'(out_log[0].dcyc - out_log[0].acyc), 64'd1);
    end

    // Random traffic with random backpressure; the compare process does the checking.
    for (int i = 0; i < 3000; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        r = $urandom;
        if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 10)];
        in_instr = r;
        in_tag   = $urandom;
      end
      tick();
    end
    drain();
    chk("final_drained", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
